serial_pattern_gen: RTL and testbench

- Transmit-side companion to the team's serial sequence detectors.
- Accepts a parallel word plus a bit count through a start/ready handshake.
- Drives the bits out MSB-first on a single serial line, one bit per clock, as a Moore-registered stream.
- Inserts a configurable idle gap between frames, and is used to generate patterns (e.g. "010") for detector-style blocks downstream.

---
 rtl/serial_pattern_gen_pkg.sv | 15 +
 rtl/serial_pattern_gen.sv | 112 +++++++++++
 tb/tb_serial_pattern_gen.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_pattern_gen_pkg.sv
// Shared types and defaults for the serial pattern generator.
// State encoding and parameter defaults live here so benches can reuse them.
package serial_pattern_gen_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_LEN_W = 4;
    localparam int DEF_GAP   = 1;

endpackage

// File: rtl/serial_pattern_gen.sv
// Serial pattern generator: parallel word in, MSB-first bit stream out,
// with a fixed idle gap between frames.
module serial_pattern_gen
    import serial_pattern_gen_pkg::*;
#(
    parameter int   WIDTH    = DEF_WIDTH,
    parameter int   LEN_W    = DEF_LEN_W,
    parameter int   GAP      = DEF_GAP,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic [LEN_W-1:0] len,
    output logic             ready,
    output logic             out,
    output logic             out_valid,
    output logic             done
);

    localparam logic [LEN_W-1:0] WMAX    = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0] CNT_TWO = LEN_W'(2);
    localparam logic [3:0]       GAP_LD  = 4'(GAP == 0 ? 0 : GAP - 1);
    localparam logic             NO_GAP  = (GAP == 0);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [LEN_W-1:0] cnt;
    logic [3:0]       gcnt;

    logic [LEN_W-1:0] eff;
    logic [WIDTH-1:0] aligned;
    logic             take;
    logic             load;

    assign eff     = (len > WMAX) ? WMAX : len;
    assign aligned = data << (WMAX - eff);
    assign take    = start && (len != '0);

    // A frame may start from IDLE, or back-to-back on the last bit when there is no gap.
    assign load = take && ((state == S_IDLE) ||
                  ((state == S_SHIFT) && (cnt == CNT_ONE) && NO_GAP));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            shreg     <= '0;
            cnt       <= '0;
            gcnt      <= '0;
            out       <= IDLE_BIT;
            out_valid <= 1'b0;
            done      <= 1'b0;
            ready     <= 1'b1;
        end else if (load) begin
            state     <= S_SHIFT;
            out       <= aligned[WIDTH-1];
            shreg     <= aligned << 1;
            cnt       <= eff;
            out_valid <= 1'b1;
            done      <= (eff == CNT_ONE);
            ready     <= (eff == CNT_ONE) && NO_GAP;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    out       <= IDLE_BIT;
                    out_valid <= 1'b0;
                    ready     <= 1'b1;
                end
                S_SHIFT: begin
                    if (cnt > CNT_ONE) begin
                        out   <= shreg[WIDTH-1];
                        shreg <= shreg << 1;
                        cnt   <= cnt - CNT_ONE;
                        done  <= (cnt == CNT_TWO);
                        ready <= (cnt == CNT_TWO) && NO_GAP;
                    end else if (!NO_GAP) begin
                        state     <= S_GAP;
                        gcnt      <= GAP_LD;
                        cnt       <= '0;
                        out       <= IDLE_BIT;
                        out_valid <= 1'b0;
                        ready     <= 1'b0;
                    end else begin
                        state     <= S_IDLE;
                        cnt       <= '0;
                        out       <= IDLE_BIT;
                        out_valid <= 1'b0;
                        ready     <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (gcnt == 4'd0) begin
                        state <= S_IDLE;
                        ready <= 1'b1;
                    end else begin
                        gcnt <= gcnt - 4'd1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out       <= IDLE_BIT;
                    out_valid <= 1'b0;
                    ready     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Bench for serial_pattern_gen: two instances (GAP=1, GAP=0) against a
// frame-schedule model, plus directed literal checks.
module tb_serial_pattern_gen;

    localparam int N = 4096;

    logic       clk = 1'b0;
    logic       reset;
    logic       start = 1'b0;
    logic [7:0] data = 8'h00;
    logic [3:0] len = 4'd0;

    logic ready0, out0, valid0, done0;
    logic ready1, out1, valid1, done1;

    int checks = 0;
    int errors = 0;
    int e = 0;
    int fl;
    bit en = 1'b0;

    bit m_out [2][N];
    bit m_val [2][N];
    bit m_done[2][N];
    bit m_rdy [2][N];

    serial_pattern_gen #(
        .WIDTH(8), .LEN_W(4), .GAP(1), .IDLE_BIT(1'b0)
    ) u_gap1 (
        .clk(clk), .reset(reset), .start(start), .data(data), .len(len),
        .ready(ready0), .out(out0), .out_valid(valid0), .done(done0)
    );

    serial_pattern_gen #(
        .WIDTH(8), .LEN_W(4), .GAP(0), .IDLE_BIT(1'b1)
    ) u_gap0 (
        .clk(clk), .reset(reset), .start(start), .data(data), .len(len),
        .ready(ready1), .out(out1), .out_valid(valid1), .done(done1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit idle_of(int g);
        return (g == 1);
    endfunction

    function automatic int gap_of(int g);
        return (g == 0) ? 1 : 0;
    endfunction

    function automatic void put(int g, int idx, bit o, bit v, bit d, bit r);
        if (idx < N) begin
            m_out[g][idx]  = o;
            m_val[g][idx]  = v;
            m_done[g][idx] = d;
            m_rdy[g][idx]  = r;
        end
    endfunction

    // Model: index k holds the outputs expected after k edges since reset release.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            e = 0;
            for (int g = 0; g < 2; g++)
                for (int i = 0; i < N; i++)
                    put(g, i, idle_of(g), 1'b0, 1'b0, 1'b1);
        end else begin
            if (start && len != 4'd0 && e < N) begin
                fl = (len > 4'd8) ? 8 : int'(len);
                for (int g = 0; g < 2; g++) begin
                    if (m_rdy[g][e]) begin
                        for (int i = 0; i < fl; i++)
                            put(g, e + 1 + i, data[fl-1-i], 1'b1, i == fl - 1,
                                gap_of(g) == 0 && i == fl - 1);
                        for (int j = 0; j < gap_of(g); j++)
                            put(g, e + 1 + fl + j, idle_of(g), 1'b0, 1'b0, 1'b0);
                    end
                end
            end
            e = e + 1;
        end
    end

    always @(negedge clk) begin
        if (en) begin
            if (e >= N) begin
                chk("model_range", e, N - 1);
            end else begin
                chk("g1_out",   out0,   m_out[0][e]);
                chk("g1_valid", valid0, m_val[0][e]);
                chk("g1_done",  done0,  m_done[0][e]);
                chk("g1_ready", ready0, m_rdy[0][e]);
                chk("g0_out",   out1,   m_out[1][e]);
                chk("g0_valid", valid1, m_val[1][e]);
                chk("g0_done",  done1,  m_done[1][e]);
                chk("g0_ready", ready1, m_rdy[1][e]);
            end
        end
    end

    logic [11:0] ovec, vvec, dvec;
    int nv, n1, nd;

    initial begin
        reset = 1'b1;
        #1 reset = 1'b0;
        #1 en = 1'b1;
        #1;
        chk("rst_out",   out0,   1'b0);
        chk("rst_valid", valid0, 1'b0);
        chk("rst_done",  done0,  1'b0);
        chk("rst_ready", ready0, 1'b1);
        chk("rst_out_g0", out1,  1'b1);
        #4 reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_ready", ready0, 1'b1);
        chk("idle_valid", valid0, 1'b0);

        // Basic frame "010"
        start = 1'b1; data = 8'b0000_0010; len = 4'd3;
        @(negedge clk); start = 1'b0;
        chk("basic_b0", {out0, valid0, ready0}, 3'b010);
        @(negedge clk);
        chk("basic_b1", {out0, valid0, done0}, 3'b110);
        @(negedge clk);
        chk("basic_b2", {out0, valid0, done0}, 3'b011);
        @(negedge clk);
        chk("basic_gap", {valid0, done0, ready0}, 3'b000);
        @(negedge clk);
        chk("basic_rdy", ready0, 1'b1);

        // Back-to-back on the GAP=0 instance
        start = 1'b1; data = 8'hA5; len = 4'd8;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) begin data = 8'h0F; len = 4'd4; end
            ovec = {ovec[10:0], out1};
            vvec = {vvec[10:0], valid1};
            dvec = {dvec[10:0], done1};
            if (i == 8) start = 1'b0;
        end
        chk("b2b_bits",  ovec, 12'hA5F);
        chk("b2b_valid", vvec, 12'hFFF);
        chk("b2b_done",  dvec, 12'h011);
        repeat (12) @(negedge clk);

        // len = 0 is ignored
        start = 1'b1; data = 8'hFF; len = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b0;
            chk("len0_valid", valid0, 1'b0);
            chk("len0_ready", ready0, 1'b1);
        end

        // len = 15 clamps to 8
        start = 1'b1; data = 8'hFF; len = 4'd15;
        nv = 0; n1 = 0; nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            nv += int'(valid0); n1 += int'(valid0 & out0); nd += int'(done0);
        end
        chk("clamp_valid", nv, 8);
        chk("clamp_ones",  n1, 8);
        chk("clamp_done",  nd, 1);

        // start while busy is dropped
        start = 1'b1; data = 8'hFF; len = 4'd8;
        nv = 0; n1 = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            if (i == 1 || i == 8) begin start = 1'b1; data = 8'h00; end
            if (i == 2 || i == 9) start = 1'b0;
            nv += int'(valid0); n1 += int'(valid0 & out0);
        end
        chk("busy_valid", nv, 8);
        chk("busy_ones",  n1, 8);
        repeat (12) @(negedge clk);

        // Abort mid-frame
        start = 1'b1; data = 8'hFF; len = 4'd8;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_g1", {out0, valid0, done0, ready0}, 4'b0001);
        chk("abort_g0", {out1, valid1, done1, ready1}, 4'b1001);
        #2 reset = 1'b1;
        @(negedge clk);
        start = 1'b1; data = 8'b0000_0010; len = 4'd2;
        @(negedge clk); start = 1'b0;
        chk("post_b0", {out0, valid0, done0}, 3'b110);
        @(negedge clk);
        chk("post_b1", {out0, valid0, done0}, 3'b011);

        // Randomized traffic
        repeat (1500) begin
            @(negedge clk);
            start = ($urandom_range(2) == 0);
            data  = 8'($urandom);
            len   = 4'($urandom);
            if ($urandom_range(399) == 0) begin
                #2 reset = 1'b0;
                #2 reset = 1'b1;
            end
        end
        start = 1'b0;
        repeat (20) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
